hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 26 ++
 rtl/hazard_ctrl.sv | 81 ++++++++
 tb/tb_hazard_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline hazard controller signal bundle
interface hazard_ctrl_if;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic        ex_MemRead_i;
    logic [4:0]  ex_wr_i;
    logic        ex_redirect_i;
    logic        mem_req_i;
    logic        dmem_ready_i;
    logic        pc_write_o;
    logic        if_id_write_o;
    logic        IF_Flush_o;
    logic        ID_Flush_o;
    logic        ex_mem_write_o;
    logic        mem_abort_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o;
    modport master (
        output id_rs1_i, id_rs2_i, ex_MemRead_i, ex_wr_i, ex_redirect_i, mem_req_i, dmem_ready_i,
        input  pc_write_o, if_id_write_o, IF_Flush_o, ID_Flush_o, ex_mem_write_o, mem_abort_o, state_o, stall_cnt_o
    );
    modport slave (
        input  id_rs1_i, id_rs2_i, ex_MemRead_i, ex_wr_i, ex_redirect_i, mem_req_i, dmem_ready_i,
        output pc_write_o, if_id_write_o, IF_Flush_o, ID_Flush_o, ex_mem_write_o, mem_abort_o, state_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, redirect and memory-wait stall/flush control
module hazard_ctrl #(
    parameter int WAIT_LIMIT = 255
) (
    input logic         clk,
    input logic         rst,
    hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd2, MEM_WAIT = 2'd3} state_t;
    localparam logic [7:0] LIM = 8'(WAIT_LIMIT);
    state_t     state, state_nx;
    logic [7:0] wait_cnt, wait_nx;
    logic       load_use, mem_stall, abort_hit;
    logic [15:0] stall_cnt;
    logic       abort_q;
    assign load_use  = bus.ex_MemRead_i && bus.ex_wr_i != 5'd0 &&
                       (bus.ex_wr_i == bus.id_rs1_i || bus.ex_wr_i == bus.id_rs2_i);
    assign mem_stall = bus.mem_req_i && !bus.dmem_ready_i;
    assign bus.state_o     = state;
    assign bus.stall_cnt_o = stall_cnt;
    assign bus.mem_abort_o = abort_q;
    // next state and pipeline enables; oldest hazard wins, held redirects act after release
    always_comb begin
        bus.pc_write_o     = 1'b1;
        bus.if_id_write_o  = 1'b1;
        bus.ex_mem_write_o = 1'b1;
        bus.IF_Flush_o     = 1'b0;
        bus.ID_Flush_o     = 1'b0;
        state_nx           = RUN;
        wait_nx            = wait_cnt;
        abort_hit          = 1'b0;
        if (state == MEM_WAIT) begin
            wait_nx = 8'd0;
            if (!bus.dmem_ready_i && wait_cnt < LIM) begin
                bus.pc_write_o     = 1'b0;
                bus.if_id_write_o  = 1'b0;
                bus.ex_mem_write_o = 1'b0;
                state_nx           = MEM_WAIT;
                wait_nx            = wait_cnt + 8'd1;
            end else if (!bus.dmem_ready_i) begin
                abort_hit = 1'b1;
            end else if (bus.ex_redirect_i) begin
                bus.IF_Flush_o = 1'b1;
                bus.ID_Flush_o = 1'b1;
                state_nx       = FLUSH;
            end else if (load_use) begin
                bus.pc_write_o    = 1'b0;
                bus.if_id_write_o = 1'b0;
                bus.ID_Flush_o    = 1'b1;
            end
        end else if (mem_stall) begin
            bus.pc_write_o     = 1'b0;
            bus.if_id_write_o  = 1'b0;
            bus.ex_mem_write_o = 1'b0;
            state_nx           = MEM_WAIT;
            wait_nx            = 8'd1;
        end else if (state == FLUSH || bus.ex_redirect_i) begin
            bus.IF_Flush_o = 1'b1;
            bus.ID_Flush_o = 1'b1;
            state_nx       = state == FLUSH ? RUN : FLUSH;
        end else if (load_use) begin
            bus.pc_write_o    = 1'b0;
            bus.if_id_write_o = 1'b0;
            bus.ID_Flush_o    = 1'b1;
        end
    end
    // state, wait counter, abort pulse and saturating lost-cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            abort_q   <= 1'b0;
            stall_cnt <= 16'd0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_nx;
            abort_q   <= abort_hit;
            stall_cnt <= ((!bus.pc_write_o || bus.IF_Flush_o) && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a cycle model
module tb_hazard_ctrl;
    localparam int LIMIT = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    bit m_wait, m_flush, m_abort;
    int m_frozen, m_stalls;
    hazard_ctrl_if bus ();
    hazard_ctrl #(.WAIT_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask
    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic mr, input logic [4:0] wr,
                          input logic rd, input logic mq, input logic rdy);
        bus.id_rs1_i = rs1;
        bus.id_rs2_i = rs2;
        bus.ex_MemRead_i = mr;
        bus.ex_wr_i = wr;
        bus.ex_redirect_i = rd;
        bus.mem_req_i = mq;
        bus.dmem_ready_i = rdy;
    endtask
    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        m_wait = 0; m_flush = 0; m_abort = 0; m_frozen = 0; m_stalls = 0;
        chk("rst_state", 16'(bus.state_o), 16'd0);
        chk("rst_stall", bus.stall_cnt_o, 16'd0);
        chk("rst_abort", 16'(bus.mem_abort_o), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask
    // one clock: predict {pc, if_id, ex_mem, IF_Flush, ID_Flush} from the hazard rules, compare, advance model
    task automatic cycle();
        logic lu, rdy;
        logic [4:0] e;
        bit n_wait, n_flush, n_abort;
        int n_frozen;
        lu = bus.ex_MemRead_i && bus.ex_wr_i != 0 && (bus.ex_wr_i == bus.id_rs1_i || bus.ex_wr_i == bus.id_rs2_i);
        rdy = bus.dmem_ready_i;
        e = 5'b11100;
        n_wait = m_wait; n_flush = m_flush; n_abort = 0; n_frozen = m_frozen;
        if (m_wait) begin
            if (!rdy && m_frozen < LIMIT) begin
                e = 5'b00000;
                n_frozen = m_frozen + 1;
            end else begin
                n_wait = 0; n_frozen = 0; n_abort = !rdy;
                if (rdy && bus.ex_redirect_i) begin e = 5'b11111; n_flush = 1; end
                else if (rdy && lu) e = 5'b00101;
            end
        end else if (bus.mem_req_i && !rdy) begin
            e = 5'b00000; n_wait = 1; n_frozen = 1; n_flush = 0;
        end else if (m_flush) begin
            e = 5'b11111; n_flush = 0;
        end else if (bus.ex_redirect_i) begin
            e = 5'b11111; n_flush = 1;
        end else if (lu) e = 5'b00101;
        @(negedge clk);
        chk("ctl", 16'({bus.pc_write_o, bus.if_id_write_o, bus.ex_mem_write_o, bus.IF_Flush_o, bus.ID_Flush_o}), 16'(e));
        chk("state", 16'(bus.state_o), m_wait ? 16'd3 : m_flush ? 16'd2 : 16'd0);
        chk("stall_cnt", bus.stall_cnt_o, 16'(m_stalls));
        chk("abort", 16'(bus.mem_abort_o), 16'(m_abort));
        @(posedge clk);
        if ((!e[4] || e[1]) && m_stalls < 65535) m_stalls++;
        m_wait = n_wait; m_flush = n_flush; m_abort = n_abort; m_frozen = n_frozen;
        #1;
    endtask
    initial begin
        do_reset();
        set_in(0, 4, 1, 0, 0, 0, 0);
        cycle();
        set_in(3, 5, 1, 5, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("lu_stall_cnt", bus.stall_cnt_o, 16'd1);
        do_reset();
        set_in(0, 0, 0, 0, 1, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        chk("redir_stall_cnt", bus.stall_cnt_o, 16'd2);
        do_reset();
        set_in(5, 0, 1, 5, 1, 1, 0);
        repeat (3) cycle();
        bus.dmem_ready_i = 1'b1;
        cycle();
        set_in(5, 0, 1, 5, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle();
        do_reset();
        set_in(0, 0, 0, 0, 0, 1, 0);
        repeat (5) cycle();
        bus.mem_req_i = 1'b0;
        cycle();
        chk("abort_state", 16'(bus.state_o), 16'd0);
        cycle();
        set_in(0, 0, 0, 0, 0, 1, 0);
        repeat (2) cycle();
        do_reset();
        set_in(0, 0, 0, 0, 1, 0, 0);
        cycle();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 2) == 0);
            cycle();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
